// File: rtl/sn_i2s_tx.sv
// I2S transmitter: divides clk into a bit clock and serialises one 8-bit sample
// per frame as a 16-bit left-justified word, duplicated on both channels.
module sn_i2s_tx #(
  parameter int BCLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sample_in,
  input  logic       mute,
  output logic       i2s_bclk,
  output logic       i2s_lrclk,
  output logic       i2s_sdata,
  output logic       frame_strobe
);

  localparam logic [7:0] DIV_LAST = 8'(BCLK_DIV - 1);

  logic [7:0]  div_cnt_q, div_cnt_d;
  logic        bclk_q, bclk_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic        lrclk_q, lrclk_d;
  logic        sdata_q, sdata_d;
  logic [15:0] word_q, word_d;
  logic        strobe_q, strobe_d;

  logic [4:0]  next_slot;
  logic [3:0]  sd_idx;

  // Slots 1..16 and 17..31 both walk the word MSB-first; slot 0 lands on bit 0
  // of the outgoing word, so the bit index is simply -slot mod 16.
  assign next_slot = bit_cnt_q + 5'd1;
  assign sd_idx    = 4'd0 - next_slot[3:0];

  always_comb begin
    div_cnt_d = div_cnt_q + 8'd1;
    bclk_d    = bclk_q;
    bit_cnt_d = bit_cnt_q;
    lrclk_d   = lrclk_q;
    sdata_d   = sdata_q;
    word_d    = word_q;
    strobe_d  = 1'b0;

    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = 8'd0;
      bclk_d    = ~bclk_q;
      if (bclk_q) begin
        bit_cnt_d = next_slot;
        lrclk_d   = next_slot[4];
        sdata_d   = word_q[sd_idx];
        if (next_slot == 5'd0) begin
          word_d   = mute ? 16'h0000 : {sample_in ^ 8'h80, 8'h00};
          strobe_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= 8'd0;
      bclk_q    <= 1'b0;
      bit_cnt_q <= 5'd31;
      lrclk_q   <= 1'b1;
      sdata_q   <= 1'b0;
      word_q    <= 16'h0000;
      strobe_q  <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
      bit_cnt_q <= bit_cnt_d;
      lrclk_q   <= lrclk_d;
      sdata_q   <= sdata_d;
      word_q    <= word_d;
      strobe_q  <= strobe_d;
    end
  end

  assign i2s_bclk     = bclk_q;
  assign i2s_lrclk    = lrclk_q;
  assign i2s_sdata    = sdata_q;
  assign frame_strobe = strobe_q;

endmodule

// File: tb/tb_sn_i2s_tx.sv
// Self-checking bench for sn_i2s_tx: a time-based frame model checks every
// cycle, and deserialised frames are compared against a table of known words.
module tb_sn_i2s_tx;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sample_in;
  logic       mute;
  logic       i2s_bclk, i2s_lrclk, i2s_sdata, frame_strobe;

  sn_i2s_tx #(.BCLK_DIV(D)) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_in   (sample_in),
    .mute        (mute),
    .i2s_bclk    (i2s_bclk),
    .i2s_lrclk   (i2s_lrclk),
    .i2s_sdata   (i2s_sdata),
    .frame_strobe(frame_strobe)
  );

  always #20 clk = ~clk;

  int testCount = 0;
  int failCount = 0;

  // Model state: n counts clk edges since the last reset-sampled edge.
  int          n;
  logic [15:0] mWord, mPrev;
  logic        expBclk, expLr, expSd, expFs;
  logic        eventNow;
  int          eventSlot;

  logic        capSlot [32];
  logic [15:0] capL, capR;
  int          doneCount = 0;
  logic        haveFrame = 1'b0;

  typedef struct {
    logic [7:0]  smp;
    logic        mu;
    logic [15:0] word;
  } vec_t;
  vec_t vecs [6];

  task automatic applyStimulus(input logic r, input logic [7:0] smp, input logic mu);
    reset     = r;
    sample_in = smp;
    mute      = mu;
  endtask

  // Predicts the outputs after the coming edge from frame arithmetic alone.
  task automatic modelPredict();
    int s;
    eventNow = 1'b0;
    expFs    = 1'b0;
    if (reset) begin
      n = 0; mWord = 16'h0; mPrev = 16'h0;
      expBclk = 1'b0; expLr = 1'b1; expSd = 1'b0;
    end else begin
      n++;
      expBclk = ((n / D) % 2) == 1;
      if (n % (2 * D) == 0) begin
        s = ((n / (2 * D)) - 1) % 32;
        eventNow  = 1'b1;
        eventSlot = s;
        if (s == 0) begin
          mPrev = mWord;
          mWord = mute ? 16'h0000 : {sample_in ^ 8'h80, 8'h00};
          expFs = 1'b1;
        end
        expLr = (s >= 16);
        if (s == 0)       expSd = mPrev[0];
        else if (s <= 16) expSd = mWord[16 - s];
        else              expSd = mWord[32 - s];
      end
    end
  endtask

  task automatic checkOutput(input string name);
    logic [3:0] act, exp;
    act = {i2s_bclk, i2s_lrclk, i2s_sdata, frame_strobe};
    exp = {expBclk, expLr, expSd, expFs};
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s n=%0d {bclk,lr,sd,fs} got %b expected %b", name, n, act, exp);
    end
  endtask

  task automatic compareInt(input string name, input int act, input int exp);
    testCount++;
    if (act != exp) begin
      failCount++;
      $display("[TB] FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkWord(input string name, input logic [15:0] exp);
    testCount++;
    if (capL !== exp || capR !== exp) begin
      failCount++;
      $display("[TB] FAIL %s left %h right %h expected %h", name, capL, capR, exp);
    end
  endtask

  task automatic stepCycle();
    modelPredict();
    @(posedge clk);
    @(negedge clk);
    checkOutput("cycle");
    if (reset) begin
      haveFrame = 1'b0;
    end else if (eventNow) begin
      if (eventSlot == 0) begin
        if (haveFrame) begin
          for (int i = 0; i < 16; i++) capL[15 - i] = capSlot[1 + i];
          for (int i = 0; i < 15; i++) capR[15 - i] = capSlot[17 + i];
          capR[0] = i2s_sdata;
          doneCount++;
        end
        haveFrame = 1'b1;
      end
      capSlot[eventSlot] = i2s_sdata;
    end
  endtask

  task automatic waitDones(input int k, input int bound);
    int start, cnt;
    start = doneCount;
    cnt   = 0;
    while (doneCount < start + k && cnt < bound) begin
      stepCycle();
      cnt++;
    end
    if (doneCount < start + k) begin
      testCount++;
      failCount++;
      $display("[TB] FAIL frame_timeout got %0d frames expected %0d", doneCount - start, k);
    end
  endtask

  task automatic countToStrobe(input string name, input int exp, input int bound);
    int cnt;
    cnt = 0;
    do begin
      stepCycle();
      cnt++;
    end while (!frame_strobe && cnt < bound);
    compareInt(name, cnt, exp);
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int prevDone;
    int cnt;
    logic [7:0] smp;
    logic mu;

    vecs[0] = '{8'h80, 1'b0, 16'h0000};
    vecs[1] = '{8'hFF, 1'b0, 16'h7F00};
    vecs[2] = '{8'h00, 1'b0, 16'h8000};
    vecs[3] = '{8'h40, 1'b0, 16'hC000};
    vecs[4] = '{8'hFF, 1'b1, 16'h0000};
    vecs[5] = '{8'h7F, 1'b0, 16'hFF00};

    applyStimulus(1'b1, 8'h80, 1'b0);
    stepCycle();
    stepCycle();
    applyStimulus(1'b0, 8'h80, 1'b0);
    countToStrobe("first_strobe", 2 * D, 20);
    countToStrobe("strobe_period", 64 * D, 300);

    for (int v = 0; v < 6; v++) begin
      applyStimulus(1'b0, vecs[v].smp, vecs[v].mu);
      waitDones(2, 600);
      checkWord("table_word", vecs[v].word);
    end

    // Sample changed mid-frame must wait for the next latch.
    applyStimulus(1'b0, 8'h00, 1'b0);
    waitDones(2, 600);
    repeat (100) stepCycle();
    applyStimulus(1'b0, 8'h40, 1'b0);
    waitDones(1, 300);
    checkWord("midchange_cur", 16'h8000);
    waitDones(1, 300);
    checkWord("midchange_next", 16'hC000);

    // Unmuting mid-frame leaves the muted frame intact.
    applyStimulus(1'b0, 8'hFF, 1'b1);
    waitDones(2, 600);
    checkWord("mute_word", 16'h0000);
    repeat (60) stepCycle();
    applyStimulus(1'b0, 8'hFF, 1'b0);
    waitDones(1, 300);
    checkWord("unmute_cur", 16'h0000);
    waitDones(1, 300);
    checkWord("unmute_next", 16'h7F00);

    // One-cycle reset inside slot 20 aborts the frame and restarts timing.
    cnt = 0;
    do begin
      stepCycle();
      cnt++;
    end while (!(eventNow && eventSlot == 20) && cnt < 300);
    compareInt("reach_slot20", eventSlot, 20);
    stepCycle();
    applyStimulus(1'b1, 8'hFF, 1'b0);
    stepCycle();
    compareInt("reset_outputs", {i2s_bclk, i2s_lrclk, i2s_sdata, frame_strobe}, 4'b0100);
    applyStimulus(1'b0, 8'hFF, 1'b0);
    countToStrobe("restart_strobe", 2 * D, 20);

    // Random traffic against the model, with occasional resets and mute flips.
    smp = 8'h80;
    mu  = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      smp = 8'($urandom);
      if ($urandom_range(0, 99) == 0) mu = ~mu;
      applyStimulus($urandom_range(0, 499) == 0, smp, mu);
      prevDone = doneCount;
      stepCycle();
      if (doneCount != prevDone) checkWord("rand_frame", mPrev);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
